// File: rtl/dt_pkg.sv
// Shared constants and state encoding for the DT result/stimulus datapath.
package dt_pkg;
  localparam int unsigned IMG_W     = 128;
  localparam int unsigned N_PIX     = IMG_W * IMG_W;
  localparam int unsigned WORD_BITS = 16;
  localparam int unsigned RES_AW    = 14;
  localparam int unsigned STI_AW    = 10;
  localparam int unsigned CNT_W     = 15;

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} pack_state_t;
endpackage

// File: rtl/bit_packer16.sv
// Serial-in word packer: shifts bits in from the LSB side and flags the
// cycle in which the incoming bit completes a word.
module bit_packer16
  import dt_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic                 bit_in,
  output logic [WORD_BITS-1:0] word_c,
  output logic                 word_valid_c
);
  localparam int unsigned BIT_CNT_W = $clog2(WORD_BITS);

  // Only the low WORD_BITS-1 bits are kept; the oldest bit leaves with the word.
  logic [WORD_BITS-2:0] shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  assign word_c       = {shift_q, bit_in};
  assign word_valid_c = shift_en && (bit_cnt_q == BIT_CNT_W'(WORD_BITS - 1));

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (clear) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (shift_en) begin
      shift_d   = word_c[WORD_BITS-2:0];
      bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end
endmodule

// File: rtl/res_binarize_pack.sv
// Reads the 8-bit result image, thresholds each pixel and writes it back
// as 1-bit-per-pixel 16-bit words (bit 15 = lowest pixel of the word).
module res_binarize_pack
  import dt_pkg::*;
#(
  parameter logic [7:0]  THRESH = 8'd0,
  parameter logic        INVERT = 1'b0,
  parameter int unsigned N_PIX  = dt_pkg::N_PIX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 res_rd,
  output logic [RES_AW-1:0]    res_addr,
  input  logic [7:0]           res_di,
  output logic                 sti_wr,
  output logic [STI_AW-1:0]    sti_waddr,
  output logic [WORD_BITS-1:0] sti_do,
  output logic [CNT_W-1:0]     ones_cnt
);
  pack_state_t          state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 res_rd_q, res_rd_d;
  logic [RES_AW-1:0]    res_addr_q, res_addr_d;
  logic                 sti_wr_q, sti_wr_d;
  logic [STI_AW-1:0]    sti_waddr_q, sti_waddr_d;
  logic [WORD_BITS-1:0] sti_do_q, sti_do_d;
  logic [CNT_W-1:0]     ones_cnt_q, ones_cnt_d;

  logic                 pix_bit_c;
  logic                 clear_c;
  logic [WORD_BITS-1:0] word_c;
  logic                 word_valid_c;

  // Read data belongs to the address issued in the cycle res_rd_q is high.
  assign pix_bit_c = (res_di > THRESH) ^ INVERT;

  bit_packer16 u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear_c),
    .shift_en     (res_rd_q),
    .bit_in       (pix_bit_c),
    .word_c       (word_c),
    .word_valid_c (word_valid_c)
  );

  always_comb begin
    state_d     = state_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    res_rd_d    = 1'b0;
    res_addr_d  = res_addr_q;
    clear_c     = 1'b0;
    sti_wr_d    = word_valid_c;
    sti_waddr_d = word_valid_c ? res_addr_q[RES_AW-1 -: STI_AW] : sti_waddr_q;
    sti_do_d    = word_valid_c ? word_c : sti_do_q;
    ones_cnt_d  = ones_cnt_q + CNT_W'(res_rd_q & pix_bit_c);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = READ;
          busy_d     = 1'b1;
          res_rd_d   = 1'b1;
          res_addr_d = '0;
          ones_cnt_d = '0;
          clear_c    = 1'b1;
        end
      end
      READ: begin
        busy_d = 1'b1;
        if (res_addr_q == RES_AW'(N_PIX - 1)) begin
          state_d = FLUSH;
        end else begin
          res_rd_d   = 1'b1;
          res_addr_d = res_addr_q + RES_AW'(1);
        end
      end
      FLUSH: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_rd_q    <= 1'b0;
      res_addr_q  <= '0;
      sti_wr_q    <= 1'b0;
      sti_waddr_q <= '0;
      sti_do_q    <= '0;
      ones_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_rd_q    <= res_rd_d;
      res_addr_q  <= res_addr_d;
      sti_wr_q    <= sti_wr_d;
      sti_waddr_q <= sti_waddr_d;
      sti_do_q    <= sti_do_d;
      ones_cnt_q  <= ones_cnt_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign res_rd    = res_rd_q;
  assign res_addr  = res_addr_q;
  assign sti_wr    = sti_wr_q;
  assign sti_waddr = sti_waddr_q;
  assign sti_do    = sti_do_q;
  assign ones_cnt  = ones_cnt_q;
endmodule

// File: tb/tb_res_binarize_pack.sv
// Bench: full-size instance (THRESH=0) and a small inverted instance
// (THRESH=3, INVERT=1, 64 pixels), each fed by a behavioural res_RAM.
module tb_res_binarize_pack;
  import dt_pkg::*;

  localparam int unsigned NB    = 64;
  localparam logic [7:0]  TH_B  = 8'h03;
  localparam logic        INV_B = 1'b1;

  typedef struct packed {
    logic [9:0]  addr;
    logic [15:0] data;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic [31:0] cyc = '0;
  int          n_assert = 0;
  int          n_fail   = 0;

  logic        a_rst, a_start, a_busy, a_done, a_rd, a_wr;
  logic [13:0] a_addr;
  logic [7:0]  a_di = '0;
  logic [9:0]  a_waddr;
  logic [15:0] a_do;
  logic [14:0] a_ones;
  logic        b_rst, b_start, b_busy, b_done, b_rd, b_wr;
  logic [13:0] b_addr;
  logic [7:0]  b_di = '0;
  logic [9:0]  b_waddr;
  logic [15:0] b_do;
  logic [14:0] b_ones;

  logic [7:0]  mem_a [N_PIX];
  logic [7:0]  mem_b [NB];
  exp_t        q_a[$];
  exp_t        q_b[$];
  int          exp_ones_a, exp_ones_b;
  int          done_cnt_a = 0;

  res_binarize_pack u_dut_a (
    .clk(clk), .reset(a_rst), .start(a_start), .busy(a_busy), .done(a_done),
    .res_rd(a_rd), .res_addr(a_addr), .res_di(a_di), .sti_wr(a_wr),
    .sti_waddr(a_waddr), .sti_do(a_do), .ones_cnt(a_ones)
  );

  res_binarize_pack #(.THRESH(TH_B), .INVERT(INV_B), .N_PIX(NB)) u_dut_b (
    .clk(clk), .reset(b_rst), .start(b_start), .busy(b_busy), .done(b_done),
    .res_rd(b_rd), .res_addr(b_addr), .res_di(b_di), .sti_wr(b_wr),
    .sti_waddr(b_waddr), .sti_do(b_do), .ones_cnt(b_ones)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // res_RAM: samples address at negedge, data valid at the next posedge
  always @(negedge clk) if (a_rd) a_di <= mem_a[a_addr];
  always @(negedge clk) if (b_rd) b_di <= mem_b[b_addr[5:0]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pix(input logic [7:0] v, input logic [7:0] th, input logic inv);
    return ((v > th) ? 1'b1 : 1'b0) ^ inv;
  endfunction

  // Scoreboard fill: word w is expected in cycle 17 + 16*w after start.
  task automatic build_a(input logic [31:0] t0);
    exp_t e;
    logic [15:0] w16;
    logic p;
    exp_ones_a = 0;
    for (int w = 0; w < int'(N_PIX / 16); w++) begin
      w16 = '0;
      for (int b = 0; b < 16; b++) begin
        p = pix(mem_a[w*16+b], 8'd0, 1'b0);
        w16[15-b] = p;
        exp_ones_a += int'(p);
      end
      e.addr = 10'(w); e.data = w16; e.cyc = t0 + 32'(17 + 16 * w);
      q_a.push_back(e);
    end
  endtask

  task automatic build_b(input logic [31:0] t0);
    exp_t e;
    logic [15:0] w16;
    logic p;
    exp_ones_b = 0;
    for (int w = 0; w < int'(NB / 16); w++) begin
      w16 = '0;
      for (int b = 0; b < 16; b++) begin
        p = pix(mem_b[w*16+b], TH_B, INV_B);
        w16[15-b] = p;
        exp_ones_b += int'(p);
      end
      e.addr = 10'(w); e.data = w16; e.cyc = t0 + 32'(17 + 16 * w);
      q_b.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_done) done_cnt_a++;
    if (a_wr) begin
      check("a_wr_expected", 64'(q_a.size() > 0), 64'd1);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("a_waddr", 64'(a_waddr), 64'(e.addr));
        check("a_wdata", 64'(a_do), 64'(e.data));
        check("a_wcycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_wr) begin
      check("b_wr_expected", 64'(q_b.size() > 0), 64'd1);
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("b_waddr", 64'(b_waddr), 64'(e.addr));
        check("b_wdata", 64'(b_do), 64'(e.data));
        check("b_wcycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic pulse_a(output logic [31:0] t0);
    @(negedge clk); a_start = 1'b1; t0 = cyc;
    @(negedge clk); a_start = 1'b0;
  endtask

  task automatic pulse_b(output logic [31:0] t0);
    @(negedge clk); b_start = 1'b1; t0 = cyc;
    @(negedge clk); b_start = 1'b0;
  endtask

  task automatic wait_done_a(input logic [31:0] t0, input string tag);
    int k = 0;
    while (!a_done && k < int'(N_PIX) + 100) begin @(negedge clk); k++; end
    check({tag, "_done_seen"}, 64'(a_done), 64'd1);
    check({tag, "_done_cycle"}, 64'(cyc - t0), 64'(N_PIX + 2));
    check({tag, "_ones"}, 64'(a_ones), 64'(exp_ones_a));
    check({tag, "_all_words"}, 64'(q_a.size()), 64'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'({a_done, a_busy, a_wr}), 64'd0);
  endtask

  task automatic wait_done_b(input logic [31:0] t0, input string tag);
    int k = 0;
    while (!b_done && k < int'(NB) + 100) begin @(negedge clk); k++; end
    check({tag, "_done_seen"}, 64'(b_done), 64'd1);
    check({tag, "_done_cycle"}, 64'(cyc - t0), 64'(NB + 2));
    check({tag, "_ones"}, 64'(b_ones), 64'(exp_ones_b));
    check({tag, "_all_words"}, 64'(q_b.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] t0;
    int          dc;
    a_rst = 1'b1; b_rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
    foreach (mem_a[i]) mem_a[i] = 8'h00;
    foreach (mem_b[i]) mem_b[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("a_reset_outputs", 64'({a_busy, a_done, a_rd, a_addr, a_wr, a_waddr, a_do, a_ones}), 64'd0);
    check("b_reset_outputs", 64'({b_busy, b_done, b_rd, b_addr, b_wr, b_waddr, b_do, b_ones}), 64'd0);
    a_rst = 1'b0; b_rst = 1'b0;

    // All-zero image: every word 0000, nothing counted
    pulse_a(t0); build_a(t0);
    check("a_first_read", 64'({a_rd, a_addr, a_busy}), 64'({1'b1, 14'd0, 1'b1}));
    wait_done_a(t0, "zeros");

    // Single pixel 17 set, plus a second start at cycle 100 that must be ignored
    mem_a[17] = 8'h05;
    pulse_a(t0); build_a(t0);
    check("single_word1_model", 64'(q_a[1].data), 64'h4000);
    repeat (99) @(negedge clk);
    a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    check("restart_ignored_addr", 64'({a_busy, a_rd, a_addr}), 64'({1'b1, 1'b1, 14'd100}));
    wait_done_a(t0, "single");
    repeat (5) @(negedge clk);
    check("ones_hold", 64'(a_ones), 64'd1);

    // All FF: every word FFFF, full count
    foreach (mem_a[i]) mem_a[i] = 8'hFF;
    pulse_a(t0); build_a(t0);
    wait_done_a(t0, "allff");
    check("do_waddr_hold", 64'({a_waddr, a_do}), 64'({10'd1023, 16'hFFFF}));

    // Random image aborted by reset at cycle 500, then rerun cleanly
    foreach (mem_a[i]) mem_a[i] = 8'($urandom);
    pulse_a(t0); build_a(t0);
    repeat (499) @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    q_a.delete();
    dc = done_cnt_a;
    check("abort_outputs", 64'({a_busy, a_done, a_rd, a_addr, a_wr, a_waddr, a_do, a_ones}), 64'd0);
    repeat (40) @(negedge clk);
    check("abort_quiet", 64'({a_busy, a_rd}), 64'd0);
    check("abort_no_done", 64'(done_cnt_a), 64'(dc));
    // Start coincident with reset: reset wins
    a_start = 1'b1; a_rst = 1'b1;
    @(negedge clk); a_start = 1'b0; a_rst = 1'b0;
    @(negedge clk);
    check("start_with_reset", 64'({a_busy, a_rd}), 64'd0);
    pulse_a(t0); build_a(t0);
    wait_done_a(t0, "rerun");

    // Small instance: threshold equality and inversion
    mem_b[0] = 8'h03; mem_b[1] = 8'h04;
    pulse_b(t0); build_b(t0);
    check("b_word0_model", 64'(q_b[0].data), 64'hBFFF);
    wait_done_b(t0, "b_thresh");
    foreach (mem_b[i]) mem_b[i] = 8'hFF;
    pulse_b(t0); build_b(t0);
    wait_done_b(t0, "b_inv_ff");
    // Start during DONE is ignored
    b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    check("b_start_in_done", 64'({b_busy, b_rd, b_done}), 64'd0);
    @(negedge clk);
    check("b_stays_idle", 64'({b_busy, b_rd}), 64'd0);
    check("b_queue_empty", 64'(q_b.size()), 64'd0);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
